// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK
    } i2c_state_e;

    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    // Cycles from a tx_req pulse to the tx_data capture.
    localparam int TX_LOAD_DELAY = 3;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes an SCL/SDA pair, filters short glitches and flags edges and
// START/STOP conditions.
module i2c_line_sync
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_cond,
    output logic stop_cond
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_q, scl_d;
    logic                   sda_q, sda_d;

    // The filtered level only moves once every sync stage agrees, so pulses
    // shorter than the synchronizer depth never reach the decision logic.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_d      = scl_q;
        sda_d      = sda_q;
        if (&scl_sync_q)       scl_d = 1'b1;
        else if (~|scl_sync_q) scl_d = 1'b0;
        if (&sda_sync_q)       sda_d = 1'b1;
        else if (~|sda_sync_q) sda_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
        end
    end

    assign scl_s      = scl_q;
    assign sda_s      = sda_q;
    assign scl_rise   = scl_d & ~scl_q;
    assign scl_fall   = ~scl_d & scl_q;
    assign start_cond = sda_q & ~sda_d & scl_q;
    assign stop_cond  = ~sda_q & sda_d & scl_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit addressing and a byte-stream user interface;
// SDA is open-drain via i2c_sda_drive_n.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl_in,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_drive_n,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    logic scl_s_unused, sda_s, scl_rise, scl_fall, start_cond, stop_cond;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (i2c_scl_in),
        .sda_in    (i2c_sda_in),
        .scl_s     (scl_s_unused),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_cond(start_cond),
        .stop_cond (stop_cond)
    );

    i2c_state_e               state_q, state_d;
    logic [2:0]               cnt_q, cnt_d;
    logic                     done_q, done_d;
    logic [7:0]               shift_q, shift_d;
    logic [7:0]               tx_shift_q, tx_shift_d;
    logic                     rw_q, rw_d;
    logic                     ack_ph_q, ack_ph_d;
    logic [TX_LOAD_DELAY-1:0] tx_pipe_q, tx_pipe_d;
    logic                     busy_q, busy_d;
    logic                     sda_drive_n_q, sda_drive_n_d;
    logic                     rx_valid_q, rx_valid_d;
    logic [7:0]               rx_data_q, rx_data_d;
    logic                     rx_first_q, rx_first_d;
    logic                     tx_req_q, tx_req_d;
    logic                     start_det_q, start_det_d;
    logic                     stop_det_q, stop_det_d;
    logic [7:0]               byte_next;

    assign byte_next = {shift_q[6:0], sda_s};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        done_d        = done_q;
        shift_d       = shift_q;
        tx_shift_d    = tx_shift_q;
        rw_d          = rw_q;
        ack_ph_d      = ack_ph_q;
        tx_pipe_d     = {tx_pipe_q[TX_LOAD_DELAY-2:0], tx_req_q};
        busy_d        = busy_q;
        sda_drive_n_d = sda_drive_n_q;
        rx_valid_d    = 1'b0;
        rx_data_d     = rx_data_q;
        rx_first_d    = rx_first_q;
        tx_req_d      = 1'b0;
        start_det_d   = 1'b0;
        stop_det_d    = 1'b0;

        if (tx_pipe_q[TX_LOAD_DELAY-1]) tx_shift_d = tx_data;
        if (rx_valid_q)                 rx_first_d = 1'b0;

        if (start_cond) begin
            start_det_d   = 1'b1;
            cnt_d         = 3'd0;
            done_d        = 1'b0;
            ack_ph_d      = 1'b0;
            sda_drive_n_d = 1'b1;
            state_d       = ST_ADDR;
        end else if (stop_cond) begin
            stop_det_d    = 1'b1;
            busy_d        = 1'b0;
            sda_drive_n_d = 1'b1;
            state_d       = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d = byte_next;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (byte_next[7:1] == ADDRESS) begin
                            busy_d   = 1'b1;
                            rw_d     = byte_next[0];
                            ack_ph_d = 1'b0;
                            state_d  = ST_ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                // First fall drives the ACK; second fall ends it and either
                // releases (write) or drives the first read MSB.
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!ack_ph_q) begin
                        sda_drive_n_d = I2C_ACK;
                        ack_ph_d      = 1'b1;
                        tx_req_d      = (rw_q == I2C_RW_READ);
                    end else begin
                        ack_ph_d = 1'b0;
                        done_d   = 1'b0;
                        if (rw_q == I2C_RW_WRITE) begin
                            sda_drive_n_d = 1'b1;
                            rx_first_d    = 1'b1;
                            cnt_d         = 3'd0;
                            state_d       = ST_WRITE;
                        end else begin
                            sda_drive_n_d = tx_shift_q[7];
                            tx_shift_d    = {tx_shift_q[6:0], 1'b0};
                            cnt_d         = 3'd1;
                            state_d       = ST_READ;
                        end
                    end
                end
                ST_WRITE: if (scl_rise) begin
                    shift_d = byte_next;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_data_d  = byte_next;
                        rx_valid_d = 1'b1;
                        ack_ph_d   = 1'b0;
                        state_d    = ST_WRITE_ACK;
                    end
                end
                ST_WRITE_ACK: if (scl_fall) begin
                    if (!ack_ph_q) begin
                        sda_drive_n_d = I2C_ACK;
                        ack_ph_d      = 1'b1;
                    end else begin
                        sda_drive_n_d = 1'b1;
                        ack_ph_d      = 1'b0;
                        cnt_d         = 3'd0;
                        state_d       = ST_WRITE;
                    end
                end
                ST_READ: if (scl_fall) begin
                    if (done_q) begin
                        sda_drive_n_d = 1'b1;
                        done_d        = 1'b0;
                        state_d       = ST_READ_ACK;
                    end else begin
                        sda_drive_n_d     = tx_shift_q[7];
                        tx_shift_d        = {tx_shift_q[6:0], 1'b0};
                        {done_d, cnt_d}   = {1'b0, cnt_q} + 4'd1;
                    end
                end
                // A NACK parks in IDLE with busy held until STOP or START.
                ST_READ_ACK: if (scl_rise) begin
                    if (sda_s == I2C_ACK) begin
                        tx_req_d = 1'b1;
                        cnt_d    = 3'd0;
                        done_d   = 1'b0;
                        state_d  = ST_READ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            done_q        <= 1'b0;
            shift_q       <= 8'h00;
            tx_shift_q    <= 8'h00;
            rw_q          <= I2C_RW_WRITE;
            ack_ph_q      <= 1'b0;
            tx_pipe_q     <= '0;
            busy_q        <= 1'b0;
            sda_drive_n_q <= 1'b1;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_first_q    <= 1'b0;
            tx_req_q      <= 1'b0;
            start_det_q   <= 1'b0;
            stop_det_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            shift_q       <= shift_d;
            tx_shift_q    <= tx_shift_d;
            rw_q          <= rw_d;
            ack_ph_q      <= ack_ph_d;
            tx_pipe_q     <= tx_pipe_d;
            busy_q        <= busy_d;
            sda_drive_n_q <= sda_drive_n_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
            rx_first_q    <= rx_first_d;
            tx_req_q      <= tx_req_d;
            start_det_q   <= start_det_d;
            stop_det_q    <= stop_det_d;
        end
    end

    assign i2c_sda_drive_n = sda_drive_n_q;
    assign rx_valid        = rx_valid_q;
    assign rx_data         = rx_data_q;
    assign rx_first        = rx_first_q;
    assign tx_req          = tx_req_q;
    assign busy            = busy_q;
    assign start_det       = start_det_q;
    assign stop_det        = stop_det_q;

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) that answers transactions from an I2C controller on the open-drain bus pins.
- Runs in the 48 MHz fabric domain next to the board top level, using the same open-drain pin split as the controller: `*_in` from the buffer, `*_drive_n` to its tristate.
- Presents received bytes and requests transmit bytes over a simple byte-stream interface.
- 7-bit addressing, no clock stretching, no general call.

Parameters:
- ADDRESS, 7'h42, 7-bit target address matched after START.
- SYNC_STAGES, 2, flop stages on `i2c_scl_in` / `i2c_sda_in` (minimum 2).

Ports:
- clk  in  1  fabric clock (48 MHz)
- rst  in  1  synchronous active-high reset
- i2c_scl_in  in  1  raw SCL from pin buffer
- i2c_sda_in  in  1  raw SDA from pin buffer
- i2c_sda_drive_n  out  1  0 = pull SDA low; 1 = release
- rx_valid  out  1  one-cycle pulse: `rx_data` holds a written byte
- rx_data  out  8  last written byte
- rx_first  out  1  qualifies `rx_valid`: first data byte after the address
- tx_req  out  1  one-cycle pulse: next read byte needed
- tx_data  in  8  read byte from user logic
- busy  out  1  high from address match until STOP or restart
- start_det  out  1  one-cycle pulse on START or repeated START
- stop_det  out  1  one-cycle pulse on STOP

Behaviour:
- Reset: synchronous, active-high.
  - Values after reset: `i2c_sda_drive_n` = 1, `rx_valid` = 0, `rx_data` = 0, `rx_first` = 0, `tx_req` = 0, `busy` = 0, `start_det` = 0, `stop_det` = 0.
  - FSM returns to IDLE.
  - Reset mid-transfer releases SDA on the next cycle.
- Input conditioning:
  - SCL and SDA each pass through SYNC_STAGES flops, then one more register for edge detect.
  - All decisions use the synchronized values `scl_s` / `sda_s`.
  - Input-to-decision latency is SYNC_STAGES+1 cycles.
- Bus conditions:
  - START = `sda_s` falls while `scl_s` is high.
  - STOP = `sda_s` rises while `scl_s` is high.
  - Data is sampled on the `scl_s` rising edge.
  - SDA may change only on the `scl_s` falling edge; SDA updates the cycle after the fall is detected.
- START and STOP take priority over every state and are honoured in every state:
  - START: pulse `start_det`, clear the bit counter, go to ADDR, release SDA.
  - STOP: pulse `stop_det`, go to IDLE, clear `busy`, release SDA.
- FSM states: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first.
    - After the 8th rise, compare bits[7:1] with ADDRESS.
    - Match: go to ADDR_ACK and set `busy`.
    - No match: go to IDLE; no SDA activity until the next START.
  - ADDR_ACK:
    - On the next SCL fall, drive SDA low.
    - On the following SCL fall, release SDA.
    - R/W = 0: go to WRITE and set `rx_first` = 1.
    - R/W = 1: go to READ.
    - `tx_req` pulses the cycle the ACK is first driven.
  - WRITE:
    - Shift 8 bits.
    - After the 8th rise, load `rx_data`, pulse `rx_valid` with the current `rx_first`, then clear `rx_first`.
    - Go to WRITE_ACK.
  - WRITE_ACK: ACK always (drive low for one SCL low-high-low window), then return to WRITE.
  - READ:
    - `tx_data` is sampled 3 cycles after the `tx_req` pulse; user logic must hold it valid from then until the next SCL fall.
    - Drive the MSB at the SCL fall that ends the ACK, then one bit per fall.
    - Bit value 1 means release SDA.
    - After the 8th bit's fall, release SDA and go to READ_ACK.
  - READ_ACK: sample SDA on the SCL rise.
    - ACK (0): pulse `tx_req` and go to READ.
    - NACK (1): go to IDLE-wait, keeping `busy` = 1 until STOP or START.
- Bit counter: 3 bits plus done flag; wraps at 8.
- Simultaneous SCL rise and START/STOP in the same cycle: the START/STOP condition wins.
- Repeated START while `busy`: `busy` stays 1 only if the new address matches.

Decomposition:
- Shared package `i2c_pkg`:
  - state enum for the FSM above
  - `I2C_ACK` = 0, `I2C_NACK` = 1
  - `I2C_RW_WRITE` = 0, `I2C_RW_READ` = 1
- One sub-module, `i2c_line_sync`: synchronizer and edge detector.
  - Outputs `scl_s`, `sda_s`, `scl_rise`, `scl_fall`, `start_cond`, `stop_cond`.
  - Reused per line pair.

Test Plan:
- Address match write: controller writes to 7'h42 (R/W=0) with data 0xA5, 0x3C, then STOP.
  - ACK on the address and both bytes.
  - `rx_valid` ×2: rx_data=0xA5 with rx_first=1, then rx_data=0x3C with rx_first=0.
  - `stop_det` pulses; `busy` falls.
- Address mismatch: write to 7'h2D.
  - SDA never driven low (`i2c_sda_drive_n` stays 1); no `rx_valid`, `busy` stays 0.
  - `start_det` and `stop_det` still pulse.
- Read with NACK: read from 7'h42, user answers `tx_req` with 0x81 then 0x7E; controller ACKs byte 1 and NACKs byte 2.
  - Bus shows 0x81, 0x7E; exactly 2 `tx_req` pulses; SDA released after the NACK.
- Repeated START: write 0x10, then repeated START, then read 1 byte with `tx_data`=0xC3.
  - `start_det` ×2; `rx_data`=0x10; bus returns 0xC3; `busy` stays high throughout.
- Reset mid-read: assert `rst` while driving bit 3 of 0x00.
  - `i2c_sda_drive_n`=1 the next cycle and all outputs at reset values.
  - A following transaction to 7'h42 completes normally.
- Glitch and boundary: with SCL high, 1-cycle SDA pulse shorter than the synchronizer depth is not detected as START; SCL period of 480 clk (100 kHz) and 120 clk (400 kHz) both pass scenario 1.
